// File: rtl/load_pkg.sv
// load_pkg: shared definitions for the load sequencer.
//   - funct3 encodings for the supported load types
//   - FSM state encoding
//   - legality helpers for funct3 and address alignment
package load_pkg;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic is_illegal_funct3(input logic [2:0] f3);
        return !(f3 inside {LB, LH, LW, LBU, LHU});
    endfunction

    // Only meaningful for legal funct3 values; byte loads are never misaligned.
    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] lane);
        logic mis;
        case (f3)
            LW:       mis = (lane != 2'b00);
            LH, LHU:  mis = lane[0];
            default:  mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/load_align.sv
// load_align: combinational lane select and sign/zero extension of a
// little-endian memory word.
// Ports:
//   rdata  [31:0] in   memory read word
//   lane   [1:0]  in   byte offset within the word (addr[1:0])
//   funct3 [2:0]  in   load type
//   data   [31:0] out  extended result (0 for unsupported funct3)
module load_align
    import load_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  lane,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata[{lane, 3'b000} +: 8];
        half_sel = rdata[{lane[1], 4'b0000} +: 16];
        case (funct3)
            LB:      data = {{24{byte_sel[7]}}, byte_sel};
            LBU:     data = {24'd0, byte_sel};
            LH:      data = {{16{half_sel[15]}}, half_sel};
            LHU:     data = {16'd0, half_sel};
            LW:      data = rdata;
            default: data = 32'd0;
        endcase
    end

endmodule

// File: rtl/load_unit.sv
// load_unit: multi-cycle load sequencer. Accepts an effective address,
// funct3 and rd, issues one word-aligned read on the req/ack interface,
// extracts and extends the addressed data and presents it for writeback
// with a one-cycle done pulse.
// Optional feature macro: LOAD_TIMEOUT_EN (adds an ack wait limit of
// TIMEOUT_CYCLES; undefined means REQ waits indefinitely).
// Ports:
//   clk, rst (async active-high)
//   start, addr[31:0], funct3[2:0], rd[4:0]     load request
//   mem_req, mem_addr[31:0], mem_ack, mem_rdata  memory read interface
//   busy, done, err, load_data[31:0], wb_rd[4:0], wb_en  status / writeback
//
// state | meaning
// IDLE  | waiting for start; request fields latched on acceptance
// REQ   | mem_req held with stable mem_addr until ack (or timeout)
// DONE  | one-cycle done pulse with result, err, wb_rd, wb_en
module load_unit
    import load_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] addr,
    input  logic [2:0]  funct3,
    input  logic [4:0]  rd,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] load_data,
    output logic [4:0]  wb_rd,
    output logic        wb_en
);

    state_t      state_q, state_d;
    logic [31:0] addr_q;
    logic [2:0]  f3_q;
    logic [4:0]  rd_q;
    logic [31:0] data_q;
    logic        err_q;

    logic        illegal;
    logic        tmo;
    logic [31:0] aligned;

    assign illegal = is_illegal_funct3(funct3) || is_misaligned(funct3, addr[1:0]);

    load_align u_align (
        .rdata  (mem_rdata),
        .lane   (addr_q[1:0]),
        .funct3 (f3_q),
        .data   (aligned)
    );

`ifdef LOAD_TIMEOUT_EN
    logic [7:0] wait_cnt_q;

    assign tmo = (state_q == REQ) && (wait_cnt_q == 8'(TIMEOUT_CYCLES));

    // Cleared whenever not in REQ, so it is zero on every REQ entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt_q <= 8'd0;
        end else if (state_q == REQ) begin
            if (!mem_ack) begin
                wait_cnt_q <= wait_cnt_q + 8'd1;
            end
        end else begin
            wait_cnt_q <= 8'd0;
        end
    end
`else
    assign tmo = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = illegal ? DONE : REQ;
                end
            end
            REQ: begin
                // ack has priority over a coincident timeout
                if (mem_ack || tmo) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= 32'd0;
            f3_q    <= 3'd0;
            rd_q    <= 5'd0;
            data_q  <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        addr_q <= addr;
                        f3_q   <= funct3;
                        rd_q   <= rd;
                        err_q  <= illegal;
                        data_q <= 32'd0;
                    end
                end
                REQ: begin
                    if (mem_ack) begin
                        data_q <= aligned;
                        err_q  <= 1'b0;
                    end else if (tmo) begin
                        data_q <= 32'd0;
                        err_q  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign mem_req   = (state_q == REQ);
    assign mem_addr  = {addr_q[31:2], 2'b00};
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign err       = done & err_q;
    assign load_data = done ? data_q : 32'd0;
    assign wb_rd     = rd_q;
    assign wb_en     = done & ~err_q & (rd_q != 5'd0);

endmodule

// File: tb/tb_load_unit.sv
// Testbench for load_unit: directed test-plan loads followed by random
// loads, all checked every cycle against expectations derived from a
// transaction-level model of the load semantics.
module tb_load_unit;
    import load_pkg::*;

    localparam int T = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] addr = 32'd0;
    logic [2:0]  funct3 = 3'd0;
    logic [4:0]  rd = 5'd0;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = 32'd0;
    logic        busy, done, err, wb_en;
    logic [31:0] load_data;
    logic [4:0]  wb_rd;

    int tests = 0;
    int fails = 0;

    bit          chk_en = 1'b0;
    logic        exp_busy, exp_mem_req, exp_done, exp_err, exp_wb_en;
    logic [31:0] exp_mem_addr, exp_data;
    logic [4:0]  exp_wb_rd;

    always #5 clk = ~clk;

    load_unit #(.TIMEOUT_CYCLES(T)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .addr      (addr),
        .funct3    (funct3),
        .rd        (rd),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .load_data (load_data),
        .wb_rd     (wb_rd),
        .wb_en     (wb_en)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Load semantics: legality and extended result from the memory word.
    function automatic void model(input logic [2:0] f3, input logic [31:0] a,
                                  input logic [31:0] d, output bit legal,
                                  output logic [31:0] res);
        logic [31:0] s;
        legal = 1'b1;
        res   = 32'd0;
        case (f3)
            LB, LBU: begin
                s = (d >> (8 * int'(a[1:0]))) & 32'h0000_00FF;
                res = (f3 == LB && s[7]) ? (s | 32'hFFFF_FF00) : s;
            end
            LH, LHU: begin
                if (a[0]) legal = 1'b0;
                else begin
                    s = (d >> (16 * int'(a[1]))) & 32'h0000_FFFF;
                    res = (f3 == LH && s[15]) ? (s | 32'hFFFF_0000) : s;
                end
            end
            LW: begin
                if (a[1:0] != 2'b00) legal = 1'b0;
                else res = d;
            end
            default: legal = 1'b0;
        endcase
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            check("busy",      32'(busy),    32'(exp_busy));
            check("mem_req",   32'(mem_req), 32'(exp_mem_req));
            if (exp_mem_req) check("mem_addr", mem_addr, exp_mem_addr);
            check("done",      32'(done),    32'(exp_done));
            check("err",       32'(err),     32'(exp_err));
            check("load_data", load_data,    exp_data);
            check("wb_en",     32'(wb_en),   32'(exp_wb_en));
            if (exp_done) check("wb_rd", 32'(wb_rd), 32'(exp_wb_rd));
        end
    end

    task automatic set_idle_exp();
        exp_busy = 0; exp_mem_req = 0; exp_done = 0; exp_err = 0;
        exp_wb_en = 0; exp_data = 0; exp_mem_addr = 0; exp_wb_rd = 0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // w = cycles of ack delay; w < 0 means ack never comes (timeout build).
    task automatic run_load(input logic [31:0] a, input logic [2:0] f3, input logic [4:0] r,
                            input logic [31:0] d, input int w, input bit extra);
        bit          legal;
        logic [31:0] res;
        int          nreq;
        model(f3, a, d, legal, res);
        set_idle_exp();
        start = 1; addr = a; funct3 = f3; rd = r;
        mem_ack = 1'($urandom); mem_rdata = $urandom;
        next_cycle();
        start = 0; addr = $urandom; funct3 = 3'($urandom); rd = 5'($urandom);
        if (!legal) begin
            exp_busy = 1; exp_done = 1; exp_err = 1; exp_wb_rd = r;
            mem_ack = 1'($urandom);
            next_cycle();
        end else begin
`ifdef LOAD_TIMEOUT_EN
            nreq = (w < 0) ? T + 1 : w + 1;
`else
            nreq = w + 1;
`endif
            for (int i = 0; i < nreq; i++) begin
                exp_busy = 1; exp_mem_req = 1; exp_mem_addr = {a[31:2], 2'b00};
                mem_ack = (i == w);
                mem_rdata = (i == w) ? d : $urandom;
                start = extra ? 1'($urandom) : 1'b0;
                next_cycle();
            end
            exp_mem_req = 0; exp_done = 1; exp_wb_rd = r;
            if (w < 0) begin
                exp_err = 1; exp_data = 0; exp_wb_en = 0;
            end else begin
                exp_err = 0; exp_data = res; exp_wb_en = (r != 5'd0);
            end
            mem_ack = 1'($urandom); mem_rdata = $urandom;
            start = extra ? 1'($urandom) : 1'b0;
            next_cycle();
        end
        set_idle_exp();
        start = 0; mem_ack = 0;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            set_idle_exp();
            start = 0; mem_ack = 1'($urandom); mem_rdata = $urandom;
            next_cycle();
        end
        mem_ack = 0;
    endtask

    initial begin
        bit          lg;
        logic [31:0] rv;

        // Pin the model with hand-computed values.
        model(LB,  32'h103, 32'h8012_3456, lg, rv); check("model_lb",  rv, 32'hFFFF_FF80);
        model(LBU, 32'h103, 32'h8012_3456, lg, rv); check("model_lbu", rv, 32'h0000_0080);
        model(LH,  32'h102, 32'h8001_1234, lg, rv); check("model_lh",  rv, 32'hFFFF_8001);
        model(LHU, 32'h102, 32'h8001_1234, lg, rv); check("model_lhu", rv, 32'h0000_8001);
        model(LH,  32'h100, 32'h8001_1234, lg, rv); check("model_lh0", rv, 32'h0000_1234);
        model(LW,  32'h102, 32'h0, lg, rv);          check("model_lw_mis", 32'(lg), 32'd0);
        model(3'b110, 32'h100, 32'h0, lg, rv);       check("model_f3_ill", 32'(lg), 32'd0);

        // Reset state.
        #12;
        check("rst_busy", 32'(busy), 0);     check("rst_mem_req", 32'(mem_req), 0);
        check("rst_done", 32'(done), 0);     check("rst_err", 32'(err), 0);
        check("rst_data", load_data, 0);     check("rst_wb_en", 32'(wb_en), 0);
        check("rst_wb_rd", 32'(wb_rd), 0);   check("rst_mem_addr", mem_addr, 0);
        @(posedge clk); #1;
        rst = 0;
        set_idle_exp();
        chk_en = 1;
        next_cycle();

        // Directed test-plan loads.
        run_load(32'h100, LW,  5'd5, 32'hDEAD_BEEF, 0, 0);
        run_load(32'h103, LB,  5'd1, 32'h8012_3456, 0, 0);
        run_load(32'h103, LBU, 5'd2, 32'h8012_3456, 1, 0);
        run_load(32'h102, LH,  5'd3, 32'h8001_1234, 0, 0);
        run_load(32'h102, LHU, 5'd4, 32'h8001_1234, 0, 0);
        run_load(32'h100, LH,  5'd6, 32'h8001_1234, 2, 0);
        run_load(32'h102, LW,  5'd7, 32'h1234_5678, 0, 0);
        run_load(32'h100, 3'b110, 5'd8, 32'h1234_5678, 0, 0);
        run_load(32'h200, LW,  5'd0, 32'hCAFE_F00D, 3, 1);
        idle_cycles(2);

        // Reset asserted in the middle of REQ.
        set_idle_exp();
        start = 1; addr = 32'h300; funct3 = LW; rd = 5'd9;
        next_cycle();
        start = 0;
        exp_busy = 1; exp_mem_req = 1; exp_mem_addr = 32'h300;
        @(negedge clk);
        #1;
        rst = 1; chk_en = 0;
        #1;
        check("rst_mid_mem_req", 32'(mem_req), 0);
        check("rst_mid_busy",    32'(busy), 0);
        check("rst_mid_done",    32'(done), 0);
        mem_ack = 1;
        next_cycle();
        check("rst_hold_done", 32'(done), 0);
        check("rst_hold_busy", 32'(busy), 0);
        rst = 0; mem_ack = 0;
        set_idle_exp();
        chk_en = 1;
        idle_cycles(2);

`ifdef LOAD_TIMEOUT_EN
        run_load(32'h400, LW, 5'd10, 32'h0, -1, 0);
        run_load(32'h404, LW, 5'd11, 32'h5555_AAAA, T, 0);
`endif

        // Random loads, including illegal and back-to-back.
        for (int n = 0; n < 300; n++) begin
            int w;
`ifdef LOAD_TIMEOUT_EN
            w = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, T));
`else
            w = int'($urandom_range(0, 5));
`endif
            run_load($urandom, 3'($urandom), 5'($urandom_range(0, 3) == 0 ? 0 : $urandom),
                     $urandom, w, 1'($urandom));
            if ($urandom_range(0, 2) == 0) idle_cycles(int'($urandom_range(1, 3)));
        end
        idle_cycles(2);
        chk_en = 0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/load_unit.md
Name: load_unit

Overview:
Multi-cycle load sequencer for the RISC core, the read-side counterpart of the store path. Takes the effective address from the ALU (base+offset) with the load's funct3 and destination register, and issues one word-aligned read on the data-memory req/ack interface. Extracts the addressed byte or halfword, sign- or zero-extends it, and presents the result for register writeback with a single-cycle done pulse.

Parameters:
TIMEOUT_CYCLES, 255, ack wait limit in cycles; used only when LOAD_TIMEOUT_EN is defined

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  load request; accepted only in IDLE
addr  input  32  effective byte address from ALU
funct3  input  3  load type: LB, LH, LW, LBU or LHU
rd  input  5  destination register index
mem_req  output  1  memory read request; held until ack
mem_addr  output  32  word address, {addr[31:2],2'b00}
mem_ack  input  1  memory accepts request; mem_rdata is valid in the same cycle
mem_rdata  input  32  memory read word, little-endian
busy  output  1  high when state != IDLE
done  output  1  one-cycle completion pulse
err  output  1  valid with done; misaligned, illegal funct3 or timeout
load_data  output  32  extended load result; valid with done
wb_rd  output  5  latched rd; valid with done
wb_en  output  1  done && !err && rd != 0

Behaviour:
- Reset (asynchronous): state IDLE; all outputs 0; mem_req drops immediately, including mid-transaction; no done is produced.
- States: IDLE, REQ, DONE.
- IDLE, start=1:
  - Latch addr, funct3 and rd.
  - If the access is illegal, go to DONE with err=1 and issue no memory access.
  - Illegal: funct3 ∈ {011,110,111}; LW with addr[1:0]≠0; LH or LHU with addr[0]≠0.
  - Otherwise go to REQ.
- REQ:
  - mem_req=1 and mem_addr stable for the whole state.
  - When mem_ack=1 is sampled, capture the extracted data and go to DONE.
- DONE: done=1 for exactly one cycle; load_data, wb_rd, wb_en and err are valid; next state IDLE.
- Outputs outside DONE: load_data, wb_en and err are 0.
- Latency:
  - Legal load: start accepted in cycle 0, mem_req in cycle 1; with ack in cycle 1, done in cycle 2. Each wait cycle adds one.
  - Illegal load: done in cycle 1.
- start while busy is ignored. A new start is accepted in the cycle after DONE, so back-to-back loads use 3 cycles minimum.
- mem_ack outside REQ is ignored.
- Extraction uses byte lane addr[1:0], little-endian:
  - LB/LBU use byte[8*lane +: 8]; LB sign-extends, LBU zero-extends.
  - LH/LHU use halfword[16*addr[1] +: 16]; LH sign-extends, LHU zero-extends.
  - LW passes mem_rdata through unchanged.
- rd=0 on a legal load: the memory read is performed, done pulses, wb_en=0.

Optional Feature:
LOAD_TIMEOUT_EN
- Defined:
  - An 8-bit wait counter clears on entry to REQ and increments each REQ cycle without ack.
  - When the count reaches TIMEOUT_CYCLES, drop mem_req and go to DONE with err=1 and load_data=0.
  - If ack and timeout occur in the same cycle, ack wins.
- Undefined: no counter is present; REQ waits indefinitely.

Decomposition:
- Package load_pkg holds:
  - funct3 constants: LB=3'b000, LH=3'b001, LW=3'b010, LBU=3'b100, LHU=3'b101.
  - State encoding: IDLE=2'd0, REQ=2'd1, DONE=2'd2.
  - Helper function is_misaligned(funct3, addr[1:0]).
- One natural sub-module: load_align, a combinational lane select plus sign/zero extend taking mem_rdata, addr[1:0] and funct3.
- The FSM, latches and timeout counter stay in load_unit.

Test Plan:
1. LW addr=0x100, rd=5, mem_rdata=0xDEADBEEF, ack in the first REQ cycle -> mem_addr=0x100; done in cycle 2; load_data=0xDEADBEEF; wb_rd=5; wb_en=1.
2. LB and LBU at addr=0x103 with rdata=0x80123456 -> mem_addr=0x100; LB gives 0xFFFFFF80, LBU gives 0x00000080.
3. LH and LHU at addr=0x102 with rdata=0x80011234 -> LH gives 0xFFFF8001, LHU gives 0x00008001; LH at addr=0x100 gives 0x00001234.
4. LW addr=0x102, then funct3=3'b110 -> mem_req never asserts; done in cycle 1 with err=1 and wb_en=0.
5. ack delayed 3 cycles with start pulsed during REQ -> mem_req and mem_addr stay stable; a single done fires in cycle 5; the extra start is dropped; rd=0 gives wb_en=0.
6. rst asserted in REQ -> mem_req and busy fall asynchronously with no done. With LOAD_TIMEOUT_EN and TIMEOUT_CYCLES=4 and no ack -> done with err=1 in cycle 6.
